// File: rtl/fire_pkg.sv
// Shared state encodings, default timing constants and output decode for the fire sequencer.
// Latency: not applicable (types and pure functions only).
// Backpressure: not applicable.
package fire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONFIRM   = 3'd1,
        ST_ALERT     = 3'd2,
        ST_SHUTDOWN  = 3'd3,
        ST_DISCHARGE = 3'd4,
        ST_VERIFY    = 3'd5,
        ST_DONE      = 3'd6,
        ST_FAULT     = 3'd7
    } fire_state_t;

    localparam int DEF_PERSIST       = 4;
    localparam int DEF_ACK_TIMEOUT   = 1000;
    localparam int DEF_DISCHARGE_LEN = 50;
    localparam int DEF_VERIFY_LEN    = 200;

    // Per-channel cockpit/actuator outputs, registered together with the state.
    typedef struct packed {
        logic warn_lamp;
        logic fuel_cut;
        logic bottle_fire;
        logic fault;
    } chan_out_t;

    // Output pattern a channel presents while sitting in a given state.
    // The lamp stays lit through the whole fire response and in FAULT; it goes
    // dark only in IDLE/CONFIRM and once the fire is confirmed out (DONE).
    // Fuel stays cut from SHUTDOWN onwards until the crew resets the channel.
    function automatic chan_out_t decode_outputs(input fire_state_t s);
        chan_out_t o;
        o = '0;
        case (s)
            ST_ALERT:     o.warn_lamp = 1'b1;
            ST_SHUTDOWN: begin
                o.warn_lamp = 1'b1;
                o.fuel_cut  = 1'b1;
            end
            ST_DISCHARGE: begin
                o.warn_lamp   = 1'b1;
                o.fuel_cut    = 1'b1;
                o.bottle_fire = 1'b1;
            end
            ST_VERIFY: begin
                o.warn_lamp = 1'b1;
                o.fuel_cut  = 1'b1;
            end
            ST_DONE:      o.fuel_cut = 1'b1;
            ST_FAULT: begin
                o.warn_lamp = 1'b1;
                o.fuel_cut  = 1'b1;
                o.fault     = 1'b1;
            end
            default:      o = '0;
        endcase
        return o;
    endfunction

    // Largest of the four timing parameters, used to size the shared counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/fire_channel.sv
// One engine's fire-response sequencer: confirm, alert, shut down, discharge, verify, latch result.
// Latency: state and outputs update together one clock after the deciding input is sampled.
// Backpressure: none; inputs are levels sampled every cycle, outputs are registered levels.
module fire_channel
    import fire_pkg::*;
#(
    parameter int PERSIST       = DEF_PERSIST,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int DISCHARGE_LEN = DEF_DISCHARGE_LEN,
    parameter int VERIFY_LEN    = DEF_VERIFY_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       overheat,
    input  logic       emergency,
    input  logic       ack,
    input  logic       pilot_reset,
    output logic       warn_lamp,
    output logic       fuel_cut,
    output logic       bottle_fire,
    output logic       fault,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(max4(PERSIST, ACK_TIMEOUT, DISCHARGE_LEN, VERIFY_LEN)) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};
    // Terminal counts: a phase ends on the cycle whose counter equals its last value.
    localparam logic [CNT_W-1:0] PERSIST_LAST   = CNT_W'(PERSIST - 1);
    localparam logic [CNT_W-1:0] ACK_LAST       = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DISCHARGE_LAST = CNT_W'(DISCHARGE_LEN - 1);
    localparam logic [CNT_W-1:0] VERIFY_LAST    = CNT_W'(VERIFY_LEN - 1);

    fire_state_t      st;
    logic [CNT_W-1:0] cnt;
    chan_out_t        outs;

    // Counter never wraps; holding at all-ones keeps a stuck phase from restarting its timer.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Channel FSM: state, phase counter and outputs all move on the same edge, so
    // outputs always reflect the state held in the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= ST_IDLE;
            cnt  <= '0;
            outs <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (emergency) begin
                        st   <= ST_SHUTDOWN;
                        outs <= decode_outputs(ST_SHUTDOWN);
                        cnt  <= '0;
                    end else if (overheat) begin
                        // This sample already counts as the first cycle of persistence.
                        st   <= ST_CONFIRM;
                        outs <= decode_outputs(ST_CONFIRM);
                        cnt  <= CNT_ONE;
                    end
                end

                ST_CONFIRM: begin
                    if (emergency) begin
                        st   <= ST_SHUTDOWN;
                        outs <= decode_outputs(ST_SHUTDOWN);
                        cnt  <= '0;
                    end else if (!overheat) begin
                        st   <= ST_IDLE;
                        outs <= decode_outputs(ST_IDLE);
                        cnt  <= '0;
                    end else if (cnt >= PERSIST_LAST) begin
                        // This sample is the PERSIST-th consecutive high one.
                        st   <= ST_ALERT;
                        outs <= decode_outputs(ST_ALERT);
                        cnt  <= '0;
                    end else begin
                        cnt  <= sat_inc(cnt);
                    end
                end

                ST_ALERT: begin
                    // Ack is checked before the overheat drop so a pulled handle is never lost.
                    if (emergency || ack) begin
                        st   <= ST_SHUTDOWN;
                        outs <= decode_outputs(ST_SHUTDOWN);
                        cnt  <= '0;
                    end else if (!overheat) begin
                        st   <= ST_IDLE;
                        outs <= decode_outputs(ST_IDLE);
                        cnt  <= '0;
                    end else if (cnt >= ACK_LAST) begin
                        st   <= ST_SHUTDOWN;
                        outs <= decode_outputs(ST_SHUTDOWN);
                        cnt  <= '0;
                    end else begin
                        cnt  <= sat_inc(cnt);
                    end
                end

                ST_SHUTDOWN: begin
                    st   <= ST_DISCHARGE;
                    outs <= decode_outputs(ST_DISCHARGE);
                    cnt  <= '0;
                end

                ST_DISCHARGE: begin
                    // The only way into DISCHARGE is through SHUTDOWN, and the only way
                    // back to SHUTDOWN is a crew reset, so the bottle fires once per reset.
                    if (cnt >= DISCHARGE_LAST) begin
                        st   <= ST_VERIFY;
                        outs <= decode_outputs(ST_VERIFY);
                        cnt  <= '0;
                    end else begin
                        cnt  <= sat_inc(cnt);
                    end
                end

                ST_VERIFY: begin
                    if (cnt >= VERIFY_LAST) begin
                        st   <= overheat ? ST_FAULT : ST_DONE;
                        outs <= decode_outputs(overheat ? ST_FAULT : ST_DONE);
                        cnt  <= '0;
                    end else begin
                        cnt  <= sat_inc(cnt);
                    end
                end

                ST_DONE, ST_FAULT: begin
                    // Latched until the crew resets with the engine no longer hot.
                    if (pilot_reset && !overheat) begin
                        st   <= ST_IDLE;
                        outs <= decode_outputs(ST_IDLE);
                        cnt  <= '0;
                    end
                end

                default: begin
                    st   <= ST_IDLE;
                    outs <= decode_outputs(ST_IDLE);
                    cnt  <= '0;
                end
            endcase
        end
    end

    assign warn_lamp   = outs.warn_lamp;
    assign fuel_cut    = outs.fuel_cut;
    assign bottle_fire = outs.bottle_fire;
    assign fault       = outs.fault;
    assign state       = st;

endmodule

// File: rtl/engine_fire_sequencer.sv
// Two-engine fire sequencer: two independent channels sharing the emergency flag.
// Latency: one clock from sampled inputs to registered outputs, per channel.
// Backpressure: none; pure level-in/level-out control block.
module engine_fire_sequencer
    import fire_pkg::*;
#(
    parameter int PERSIST       = DEF_PERSIST,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int DISCHARGE_LEN = DEF_DISCHARGE_LEN,
    parameter int VERIFY_LEN    = DEF_VERIFY_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eng1o,
    input  logic       eng2o,
    input  logic       emergencySignal,
    input  logic [1:0] pilot_ack,
    input  logic       pilot_reset,
    output logic [1:0] warn_lamp,
    output logic [1:0] fuel_cut,
    output logic [1:0] bottle_fire,
    output logic [1:0] fault,
    output logic [2:0] state1,
    output logic [2:0] state2
);

    fire_channel #(
        .PERSIST       (PERSIST),
        .ACK_TIMEOUT   (ACK_TIMEOUT),
        .DISCHARGE_LEN (DISCHARGE_LEN),
        .VERIFY_LEN    (VERIFY_LEN)
    ) u_chan1 (
        .clk         (clk),
        .rst         (rst),
        .overheat    (eng1o),
        .emergency   (emergencySignal),
        .ack         (pilot_ack[0]),
        .pilot_reset (pilot_reset),
        .warn_lamp   (warn_lamp[0]),
        .fuel_cut    (fuel_cut[0]),
        .bottle_fire (bottle_fire[0]),
        .fault       (fault[0]),
        .state       (state1)
    );

    fire_channel #(
        .PERSIST       (PERSIST),
        .ACK_TIMEOUT   (ACK_TIMEOUT),
        .DISCHARGE_LEN (DISCHARGE_LEN),
        .VERIFY_LEN    (VERIFY_LEN)
    ) u_chan2 (
        .clk         (clk),
        .rst         (rst),
        .overheat    (eng2o),
        .emergency   (emergencySignal),
        .ack         (pilot_ack[1]),
        .pilot_reset (pilot_reset),
        .warn_lamp   (warn_lamp[1]),
        .fuel_cut    (fuel_cut[1]),
        .bottle_fire (bottle_fire[1]),
        .fault       (fault[1]),
        .state       (state2)
    );

endmodule

// File: tb/tb_engine_fire_sequencer.sv
// Bench for engine_fire_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a timestamp-based reference model.
module tb_engine_fire_sequencer;

    localparam int P  = 4;
    localparam int AT = 10;
    localparam int DL = 5;
    localparam int VL = 8;

    localparam int IDLE = 0, CONFIRM = 1, ALERT = 2, SHUTDOWN = 3;
    localparam int DISCH = 4, VERIFY = 5, DONE = 6, FAULT = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       eng1o, eng2o, emergencySignal, pilot_reset;
    logic [1:0] pilot_ack;
    logic [1:0] warn_lamp, fuel_cut, bottle_fire, fault;
    logic [2:0] state1, state2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    engine_fire_sequencer #(
        .PERSIST       (P),
        .ACK_TIMEOUT   (AT),
        .DISCHARGE_LEN (DL),
        .VERIFY_LEN    (VL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .eng1o           (eng1o),
        .eng2o           (eng2o),
        .emergencySignal (emergencySignal),
        .pilot_ack       (pilot_ack),
        .pilot_reset     (pilot_reset),
        .warn_lamp       (warn_lamp),
        .fuel_cut        (fuel_cut),
        .bottle_fire     (bottle_fire),
        .fault           (fault),
        .state1          (state1),
        .state2          (state2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is tracked as a phase plus the edge number at which it was entered;
    // durations are plain differences of edge counts.
    int ph[2];
    int t0[2];
    int mcyc;

    function automatic int next_phase(input int p, input int spent, input bit ov,
                                      input bit em, input bit ak, input bit pr);
        case (p)
            IDLE:     return em ? SHUTDOWN : (ov ? CONFIRM : IDLE);
            CONFIRM:  begin
                if (em)  return SHUTDOWN;
                if (!ov) return IDLE;
                // samples high so far = cycles in CONFIRM + the IDLE sample
                return (spent + 1 >= P) ? ALERT : CONFIRM;
            end
            ALERT:    begin
                if (em || ak) return SHUTDOWN;
                if (!ov)      return IDLE;
                return (spent >= AT) ? SHUTDOWN : ALERT;
            end
            SHUTDOWN: return DISCH;
            DISCH:    return (spent >= DL) ? VERIFY : DISCH;
            VERIFY:   return (spent >= VL) ? (ov ? FAULT : DONE) : VERIFY;
            default:  return (pr && !ov) ? IDLE : p;
        endcase
    endfunction

    function automatic bit m_warn(input int p);
        return (p == ALERT) || (p == SHUTDOWN) || (p == DISCH) || (p == VERIFY) || (p == FAULT);
    endfunction
    function automatic bit m_fuel(input int p);
        return p >= SHUTDOWN;
    endfunction
    function automatic bit m_bottle(input int p);
        return p == DISCH;
    endfunction
    function automatic bit m_fault(input int p);
        return p == FAULT;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph[0] <= IDLE; ph[1] <= IDLE;
            t0[0] <= 0;    t0[1] <= 0;
            mcyc  <= 0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (next_phase(ph[n], mcyc - t0[n], (n == 0) ? eng1o : eng2o,
                               emergencySignal, pilot_ack[n], pilot_reset) != ph[n]) begin
                    ph[n] <= next_phase(ph[n], mcyc - t0[n], (n == 0) ? eng1o : eng2o,
                                        emergencySignal, pilot_ack[n], pilot_reset);
                    t0[n] <= mcyc;
                end
            end
            mcyc <= mcyc + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("model_state1", 32'(state1), 32'(ph[0]));
            chk("model_state2", 32'(state2), 32'(ph[1]));
            chk("model_warn",   32'(warn_lamp),   32'({m_warn(ph[1]),   m_warn(ph[0])}));
            chk("model_fuel",   32'(fuel_cut),    32'({m_fuel(ph[1]),   m_fuel(ph[0])}));
            chk("model_bottle", 32'(bottle_fire), 32'({m_bottle(ph[1]), m_bottle(ph[0])}));
            chk("model_fault",  32'(fault),       32'({m_fault(ph[1]),  m_fault(ph[0])}));
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        eng1o = 0; eng2o = 0; emergencySignal = 0; pilot_ack = 2'b00; pilot_reset = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    function automatic logic [2:0] cur(input int ch);
        return (ch == 0) ? state1 : state2;
    endfunction

    task automatic wait_for(input int ch, input int val, input int lim, input string nm);
        int k;
        k = 0;
        while (cur(ch) != 3'(val) && k < lim) begin
            step();
            k++;
        end
        chk(nm, 32'(cur(ch)), 32'(val));
    endtask

    typedef struct {
        logic       o1, o2, emg, prst;
        logic [1:0] ack;
        logic [2:0] s1, s2;
        logic [1:0] warn, fuel, bottle, flt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic o1, input logic o2, input logic emg,
                                input logic [1:0] ack, input logic prst,
                                input logic [2:0] s1, input logic [2:0] s2,
                                input logic [1:0] warn, input logic [1:0] fuel,
                                input logic [1:0] bottle, input logic [1:0] flt);
        vec_t v;
        v.o1 = o1; v.o2 = o2; v.emg = emg; v.ack = ack; v.prst = prst;
        v.s1 = s1; v.s2 = s2; v.warn = warn; v.fuel = fuel; v.bottle = bottle; v.flt = flt;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, na;

        // Short overheat (3 cycles) must fall back to IDLE with the lamp dark,
        // then a one-cycle emergency pulse drives both channels through the full response.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,2'b00,0, 3'd1,3'd0, 2'b00,2'b00,2'b00,2'b00));
        tbl.push_back(mk(0,0,0,2'b00,0, 3'd0,3'd0, 2'b00,2'b00,2'b00,2'b00));
        tbl.push_back(mk(0,0,0,2'b00,0, 3'd0,3'd0, 2'b00,2'b00,2'b00,2'b00));
        tbl.push_back(mk(0,0,1,2'b00,0, 3'd3,3'd3, 2'b11,2'b11,2'b00,2'b00));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,2'b00,0, 3'd4,3'd4, 2'b11,2'b11,2'b11,2'b00));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0,0,0,2'b00,0, 3'd5,3'd5, 2'b11,2'b11,2'b00,2'b00));
        tbl.push_back(mk(0,0,0,2'b00,0, 3'd6,3'd6, 2'b00,2'b11,2'b00,2'b00));
        tbl.push_back(mk(0,0,0,2'b00,1, 3'd0,3'd0, 2'b00,2'b00,2'b00,2'b00));

        // Reset state.
        clear_inputs();
        rst = 1;
        step();
        chk("rst_state1", 32'(state1), 0);
        chk("rst_state2", 32'(state2), 0);
        chk("rst_warn",   32'(warn_lamp), 0);
        chk("rst_fuel",   32'(fuel_cut), 0);
        chk("rst_bottle", 32'(bottle_fire), 0);
        chk("rst_fault",  32'(fault), 0);
        rst = 0;

        foreach (tbl[i]) begin
            eng1o = tbl[i].o1; eng2o = tbl[i].o2; emergencySignal = tbl[i].emg;
            pilot_ack = tbl[i].ack; pilot_reset = tbl[i].prst;
            step();
            chk($sformatf("vec%0d_state1", i), 32'(state1), 32'(tbl[i].s1));
            chk($sformatf("vec%0d_state2", i), 32'(state2), 32'(tbl[i].s2));
            chk($sformatf("vec%0d_warn", i),   32'(warn_lamp), 32'(tbl[i].warn));
            chk($sformatf("vec%0d_fuel", i),   32'(fuel_cut), 32'(tbl[i].fuel));
            chk($sformatf("vec%0d_bottle", i), 32'(bottle_fire), 32'(tbl[i].bottle));
            chk($sformatf("vec%0d_fault", i),  32'(fault), 32'(tbl[i].flt));
        end

        // Engine 1: ack on the second ALERT cycle, fire cleared before VERIFY ends -> DONE.
        do_reset();
        eng1o = 1;
        wait_for(0, ALERT, 20, "e1_reach_alert");
        step();
        chk("e1_alert_2nd_cycle", 32'(state1), ALERT);
        pilot_ack = 2'b01;
        step();
        pilot_ack = 2'b00;
        chk("e1_ack_shutdown", 32'(state1), SHUTDOWN);
        chk("e1_fuel_cut", 32'(fuel_cut), 32'(2'b01));
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bottle_fire[0]) nb++;
        end
        chk("e1_bottle_cycles", 32'(nb), DL);
        eng1o = 0;
        wait_for(0, DONE, 20, "e1_reach_done");
        chk("e1_done_fault", 32'(fault), 0);
        chk("e1_done_fuel",  32'(fuel_cut), 32'(2'b01));
        chk("e1_done_warn",  32'(warn_lamp), 0);

        // Engine 2: no ack -> timeout after AT ALERT cycles; still hot at VERIFY expiry -> FAULT.
        do_reset();
        eng2o = 1;
        wait_for(1, ALERT, 20, "e2_reach_alert");
        na = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (state2 == 3'(ALERT)) na++;
            else break;
        end
        chk("e2_alert_cycles", 32'(na), AT);
        chk("e2_timeout_shutdown", 32'(state2), SHUTDOWN);
        wait_for(1, FAULT, 40, "e2_reach_fault");
        chk("e2_fault_bits", 32'(fault), 32'(2'b10));
        pilot_reset = 1;
        step();
        chk("e2_reset_while_hot_holds", 32'(state2), FAULT);
        eng2o = 0;
        step();
        pilot_reset = 0;
        chk("e2_reset_to_idle", 32'(state2), IDLE);
        chk("e2_fault_cleared", 32'(fault), 0);

        // Reset in the third DISCHARGE cycle clears drives immediately.
        do_reset();
        emergencySignal = 1;
        step();
        emergencySignal = 0;
        step();
        step();
        step();
        chk("rstd_bottle_before", 32'(bottle_fire), 32'(2'b11));
        rst = 1;
        #1;
        chk("rstd_bottle", 32'(bottle_fire), 0);
        chk("rstd_fuel",   32'(fuel_cut), 0);
        chk("rstd_state1", 32'(state1), 0);
        step();
        rst = 0;

        // Ack and overheat drop in the same ALERT cycle: ack wins.
        do_reset();
        eng1o = 1;
        wait_for(0, ALERT, 20, "race_reach_alert");
        pilot_ack = 2'b01;
        eng1o = 0;
        step();
        pilot_ack = 2'b00;
        chk("race_ack_wins", 32'(state1), SHUTDOWN);

        // Randomized traffic, checked every cycle against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) eng1o = ~eng1o;
            if ($urandom_range(0, 7) == 0) eng2o = ~eng2o;
            emergencySignal = ($urandom_range(0, 63) == 0);
            pilot_ack[0]    = ($urandom_range(0, 15) == 0);
            pilot_ack[1]    = ($urandom_range(0, 15) == 0);
            pilot_reset     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1;
                step();
                rst = 0;
            end else begin
                step();
            end
        end

        clear_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
